// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB3 completer and its register-file memory.
package apb_slave_pkg;

  localparam int unsigned DEF_AW    = 8;
  localparam int unsigned DEF_DW    = 8;
  localparam int unsigned DEF_DEPTH = 64;
  localparam int unsigned DEF_WAIT  = 1;

  localparam int unsigned CNT_W = 4;

  localparam logic        RESP_OKAY  = 1'b0;
  localparam logic        RESP_ERR   = 1'b1;
  localparam int unsigned RD_DEFAULT = 0;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Word address outside the implemented memory.
  function automatic logic addr_err(input int unsigned addr, input int unsigned depth);
    return (addr >= depth) ? RESP_ERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/apb_slave_if.sv
// APB3 bus between one master decode output and one completer.
interface apb_slave_if
  import apb_slave_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
) ();

  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_slave_mem.sv
// DEPTH x DW register file: async clear, one synchronous write port, one combinational read port.
module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata_c
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (we && !addr_err(32'(waddr), DEPTH)) begin
      mem[IW'(waddr)] <= wdata;
    end
  end

  // Out-of-range reads never index the array.
  always_comb begin
    rdata_c = DW'(RD_DEFAULT);
    if (!addr_err(32'(raddr), DEPTH)) rdata_c = mem[IW'(raddr)];
  end

endmodule

// File: rtl/apb_slave.sv
// APB3 completer: latches the setup phase, counts wait states, then answers from the register file.
module apb_slave
  import apb_slave_pkg::*;
#(
  parameter int unsigned AW          = DEF_AW,
  parameter int unsigned DW          = DEF_DW,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT
) (
  input logic       pclk,
  input logic       presetn,
  apb_slave_if.slave bus
);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [AW-1:0]    addr, addr_nxt;
  logic             wr, wr_nxt;
  logic [DW-1:0]    wdata, wdata_nxt;
  logic             pready_q, pready_nxt;
  logic             pslverr_q, pslverr_nxt;
  logic [DW-1:0]    prdata_q, prdata_nxt;

  logic             setup_c, done_c, xfer_wr_c, err_c, we_c;
  logic [AW-1:0]    raddr_c;
  logic [DW-1:0]    rdata_c, resp_data_c;

  assign setup_c = bus.psel && !bus.penable;
  assign done_c  = bus.psel && bus.penable && pready_q;

  // In IDLE the response is formed from the live setup inputs (zero-wait case).
  assign raddr_c     = (state == IDLE) ? bus.paddr  : addr;
  assign xfer_wr_c   = (state == IDLE) ? bus.pwrite : wr;
  assign err_c       = addr_err(32'(raddr_c), DEPTH);
  assign resp_data_c = (xfer_wr_c || err_c) ? DW'(RD_DEFAULT) : rdata_c;
  assign we_c        = (state == ACCESS) && done_c && wr && !err_c;

  apb_slave_mem #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (pclk),
    .rst_n   (presetn),
    .we      (we_c),
    .waddr   (addr),
    .wdata   (wdata),
    .raddr   (raddr_c),
    .rdata_c (rdata_c)
  );

  // State and datapath registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      cnt       <= '0;
      addr      <= '0;
      wr        <= 1'b0;
      wdata     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      addr      <= addr_nxt;
      wr        <= wr_nxt;
      wdata     <= wdata_nxt;
      pready_q  <= pready_nxt;
      pslverr_q <= pslverr_nxt;
      prdata_q  <= prdata_nxt;
    end
  end

  // Next state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (setup_c) state_nxt = ACCESS;
      ACCESS:  if (!bus.psel || done_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of counter, latched request and registered response.
  always_comb begin
    cnt_nxt     = cnt;
    addr_nxt    = addr;
    wr_nxt      = wr;
    wdata_nxt   = wdata;
    pready_nxt  = pready_q;
    pslverr_nxt = pslverr_q;
    prdata_nxt  = prdata_q;
    case (state)
      IDLE: begin
        if (setup_c) begin
          addr_nxt  = bus.paddr;
          wr_nxt    = bus.pwrite;
          wdata_nxt = bus.pwdata;
          cnt_nxt   = CNT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            pready_nxt  = 1'b1;
            pslverr_nxt = err_c;
            prdata_nxt  = resp_data_c;
          end
        end
      end
      ACCESS: begin
        if (!bus.psel || done_c) begin
          cnt_nxt     = '0;
          pready_nxt  = 1'b0;
          pslverr_nxt = 1'b0;
          prdata_nxt  = '0;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            pready_nxt  = 1'b1;
            pslverr_nxt = err_c;
            prdata_nxt  = resp_data_c;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign bus.prdata  = prdata_q;

endmodule

// File: tb/tb_apb_slave.sv
// Two completers (0 and 1 wait states) behind per-slave psel; directed table, corner sequences, random traffic.
module tb_apb_slave;

  localparam int unsigned DEPTH = 64;

  logic       pclk;
  logic       presetn;
  logic [1:0] psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;

  apb_slave_if #(.AW(8), .DW(8)) if0 ();
  apb_slave_if #(.AW(8), .DW(8)) if1 ();

  assign if0.psel    = psel[0];
  assign if0.penable = penable;
  assign if0.pwrite  = pwrite;
  assign if0.paddr   = paddr;
  assign if0.pwdata  = pwdata;
  assign if1.psel    = psel[1];
  assign if1.penable = penable;
  assign if1.pwrite  = pwrite;
  assign if1.paddr   = paddr;
  assign if1.pwdata  = pwdata;

  apb_slave #(.AW(8), .DW(8), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .pclk(pclk), .presetn(presetn), .bus(if0)
  );
  apb_slave #(.AW(8), .DW(8), .DEPTH(DEPTH), .WAIT_CYCLES(1)) u_dut1 (
    .pclk(pclk), .presetn(presetn), .bus(if1)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference: plain word arrays per slave; slave index equals its wait-state count.
  logic [7:0] model [2][DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic get_ready(input int s);
    return (s == 1) ? if1.pready : if0.pready;
  endfunction
  function automatic logic get_err(input int s);
    return (s == 1) ? if1.pslverr : if0.pslverr;
  endfunction
  function automatic logic [7:0] get_rdata(input int s);
    return (s == 1) ? if1.prdata : if0.prdata;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < int'(DEPTH); i++) model[s][i] = 8'h00;
  endfunction

  function automatic void model_write(input int s, input logic [7:0] a, input logic [7:0] d);
    if (int'(a) < int'(DEPTH)) model[s][a] = d;
  endfunction

  // One APB transfer starting at a negedge; leaves the bus idle at the negedge after completion.
  task automatic xfer(input int s, input bit wr, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] exp_rd, input bit exp_err, input string tag);
    int  cycles;
    bit  seen;
    psel    = 2'b00;
    psel[s] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    @(negedge pclk);
    penable = 1'b1;
    cycles  = 1;
    seen    = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycles++;
      if (get_ready(s)) begin
        seen = 1'b1;
        break;
      end
      @(negedge pclk);
    end
    if (!seen) begin
      check({tag, "_pready_timeout"}, 32'(0), 32'(1));
      psel = 2'b00;
      penable = 1'b0;
      return;
    end
    check({tag, "_cycles"}, 32'(cycles), 32'(s + 2));
    check({tag, "_pslverr"}, 32'(get_err(s)), 32'(exp_err));
    if (!wr) check({tag, "_prdata"}, 32'(get_rdata(s)), 32'(exp_rd));
    @(negedge pclk);
    psel    = 2'b00;
    penable = 1'b0;
    check({tag, "_idle_outputs"}, {22'd0, get_ready(s), get_err(s), get_rdata(s)}, 32'(0));
  endtask

  typedef struct {
    int         s;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
    bit         exp_err;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, d, er;
    bit         w, e;
    int         s;

    vecs[0]  = '{1, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0};
    vecs[1]  = '{1, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0};
    vecs[2]  = '{0, 1'b1, 8'h00, 8'h3C, 8'h00, 1'b0};
    vecs[3]  = '{0, 1'b1, 8'h3F, 8'hC3, 8'h00, 1'b0};
    vecs[4]  = '{0, 1'b0, 8'h00, 8'h00, 8'h3C, 1'b0};
    vecs[5]  = '{0, 1'b0, 8'h3F, 8'h00, 8'hC3, 1'b0};
    vecs[6]  = '{1, 1'b1, 8'h40, 8'hFF, 8'h00, 1'b1};
    vecs[7]  = '{1, 1'b0, 8'h40, 8'h00, 8'h00, 1'b1};
    vecs[8]  = '{1, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0};
    vecs[9]  = '{1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[10] = '{0, 1'b1, 8'hFF, 8'hEE, 8'h00, 1'b1};
    vecs[11] = '{0, 1'b0, 8'h3F, 8'h00, 8'hC3, 1'b0};
    vecs[12] = '{1, 1'b1, 8'h3F, 8'h5A, 8'h00, 1'b0};
    vecs[13] = '{1, 1'b0, 8'h3F, 8'h00, 8'h5A, 1'b0};

    presetn = 1'b0;
    psel    = 2'b00;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 8'h00;
    pwdata  = 8'h00;
    model_clear();
    repeat (2) @(negedge pclk);
    check("reset_outputs_s0", {22'd0, get_ready(0), get_err(0), get_rdata(0)}, 32'(0));
    check("reset_outputs_s1", {22'd0, get_ready(1), get_err(1), get_rdata(1)}, 32'(0));
    presetn = 1'b1;
    @(negedge pclk);

    // Directed vectors, issued back-to-back.
    for (int i = 0; i < 14; i++) begin
      xfer(vecs[i].s, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp_rd, vecs[i].exp_err,
           $sformatf("vec%0d", i));
      if (vecs[i].wr) model_write(vecs[i].s, vecs[i].addr, vecs[i].data);
    end

    // Reset asserted while slave 1 is presenting a ready read response.
    @(negedge pclk);
    psel    = 2'b10;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 8'h10;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    check("pre_reset_ready", 32'(get_ready(1)), 32'(1));
    presetn = 1'b0;
    #1;
    check("midreset_outputs_s1", {22'd0, get_ready(1), get_err(1), get_rdata(1)}, 32'(0));
    check("midreset_outputs_s0", {22'd0, get_ready(0), get_err(0), get_rdata(0)}, 32'(0));
    repeat (3) @(negedge pclk);
    psel    = 2'b00;
    penable = 1'b0;
    presetn = 1'b1;
    model_clear();
    @(negedge pclk);
    xfer(1, 1'b0, 8'h05, 8'h00, 8'h00, 1'b0, "post_reset_rd05");
    xfer(1, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0, "post_reset_rd10");
    xfer(0, 1'b0, 8'h3F, 8'h00, 8'h00, 1'b0, "post_reset_s0_rd3f");

    // Abort: psel drops during the wait state of a write.
    psel    = 2'b10;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h20;
    pwdata  = 8'h77;
    @(negedge pclk);
    psel = 2'b00;
    @(negedge pclk);
    check("abort_pready", 32'(get_ready(1)), 32'(0));
    @(negedge pclk);
    xfer(1, 1'b0, 8'h20, 8'h00, model[1][8'h20], 1'b0, "abort_rd20");

    // Protocol violation: access phase without a setup phase.
    psel    = 2'b10;
    penable = 1'b1;
    pwrite  = 1'b1;
    paddr   = 8'h11;
    pwdata  = 8'h99;
    for (int k = 0; k < 3; k++) begin
      @(negedge pclk);
      check($sformatf("noset_pready%0d", k), 32'(get_ready(1)), 32'(0));
    end
    psel    = 2'b00;
    penable = 1'b0;
    @(negedge pclk);
    xfer(1, 1'b0, 8'h11, 8'h00, model[1][8'h11], 1'b0, "noset_rd11");

    // Random traffic against the array model, including out-of-range addresses.
    for (int i = 0; i < 300; i++) begin
      s  = int'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 71));
      if ($urandom_range(0, 19) == 0) a = 8'($urandom_range(64, 255));
      d  = 8'($urandom);
      e  = (int'(a) >= int'(DEPTH));
      er = (w || e) ? 8'h00 : model[s][a];
      xfer(s, w, a, d, er, e, $sformatf("rnd%0d", i));
      if (w) model_write(s, a, d);
      repeat ($urandom_range(0, 2)) @(negedge pclk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apb_slave.md
# apb_slave

APB3 completer (slave) with a local register-file memory and programmable wait states; the responder at the far end of the APB bus driven by the team's APB master. Two instances sit behind the master's address decode, one per `psel`, forming the two-slave subsystem. Each instance services single read/write transfers, inserts a fixed number of wait states and flags out-of-range addresses with `pslverr`.

## Interface
- `AW`, default `` `AW `` (8): address width.
- `DW`, default `` `DW `` (8): data width.
- `DEPTH`, default 64: memory words; legal addresses are 0..DEPTH-1. Must satisfy DEPTH <= 2^AW.
- `WAIT_CYCLES`, default 1: wait states inserted before `pready`; range 0..15.
- `pclk`  in  1  bus clock; everything is sampled on the rising edge.
- `presetn`  in  1  reset; asynchronous assertion, active-low.
- `psel`  in  1  slave select from the master decode.
- `penable`  in  1  access phase indicator.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  AW  word address.
- `pwdata`  in  DW  write data.
- `prdata`  out  DW  read data; valid only while `pready`=1 on a read.
- `pready`  out  1  transfer complete.
- `pslverr`  out  1  error response; valid only while `pready`=1.

## Operation
- FSM states: IDLE, ACCESS.
- **IDLE**
  - On an edge with `psel`=1 and `penable`=0 (setup sampled), latch `paddr`, `pwrite` and `pwdata`.
  - Load the wait counter with WAIT_CYCLES and move to ACCESS.
  - Register `pready` = (WAIT_CYCLES==0).
- **ACCESS**
  - While the counter is nonzero, decrement it each edge and hold `pready`=0.
  - On the edge where the counter reaches 0, register `pready`=1.
  - On the edge where `psel`=1, `penable`=1 and `pready`=1 are all sampled, the transfer completes:
    - Write: `mem[addr]` <= latched `pwdata`.
    - Clear `pready` and `pslverr`, and return to IDLE.
- **Read data**: `prdata` is registered together with `pready`. It carries `mem[addr]`, or 0 on error. Between transfers it holds 0.
- **Error**: a latched address >= DEPTH sets `pslverr`=1 alongside `pready`=1. A write is suppressed and a read returns 0.
- **Aborts and protocol violations**:
  - `psel` dropping in ACCESS before completion: return to IDLE, no write, outputs cleared.
  - `penable`=1 sampled in IDLE without a setup phase: ignored, stay in IDLE.
  - A new setup on the same edge as completion is not recognised; the master must insert the IDLE/SETUP phase, as required by APB.
- **Reset** (asynchronous, including mid-transfer):
  - State goes to IDLE, counter to 0.
  - `prdata`=0, `pready`=0, `pslverr`=0.
  - All memory words are cleared to 0.
  - No write completes for a transfer interrupted by reset.

## Timing
- Let E0 be the edge sampling setup (`psel`=1, `penable`=0).
- `pready` goes high after edge E0+WAIT_CYCLES.
- The transfer completes at edge E0+WAIT_CYCLES+1.
- Total transfer = WAIT_CYCLES+2 cycles. With WAIT_CYCLES=0 this is the 2-cycle minimum APB transfer.
- Write data is visible to a read whose setup is sampled at any edge after completion.
- `pready`, `pslverr` and `prdata` are registered outputs; there is no combinational path from inputs to outputs.

## Structure
- Package `apb_slave_pkg`: state enum {IDLE, ACCESS}, counter width constant (4 bits), error and read-default constants.
- Sub-module `apb_slave_mem`:
  - DEPTH x DW register array with asynchronous clear.
  - One synchronous write port (`we`, `waddr`, `wdata`) and one combinational read port.
- The top level holds the FSM, wait counter, address-range check and output registers.

## Test plan
- Reset: hold `presetn`=0 for 3 cycles mid-stream -> `prdata`=0, `pready`=0, `pslverr`=0; a subsequent read of address 0x05 returns 0x00.
- WAIT_CYCLES=1: write 0xA5 to 0x10, then read 0x10 -> `pready` high on the 3rd cycle of each transfer, read returns 0xA5, `pslverr`=0.
- WAIT_CYCLES=0 back-to-back: write 0x3C to 0x00, then write 0xC3 to 0x3F, then read both -> each transfer takes 2 cycles, reads return 0x3C and 0xC3.
- Out of range (DEPTH=64): write 0xFF to 0x40, then read 0x40 -> `pslverr`=1 with `pready`=1 on both, read returns 0x00, no memory word altered.
- Abort: setup a write of 0x77 to 0x20, drop `psel` during a wait state, then read 0x20 -> returns the previous value 0x00.
- Protocol violation: `penable`=1 with `psel`=1 and no preceding setup -> `pready` stays 0 and the FSM stays in IDLE.
